// File: rtl/serial_reg_file_pkg.sv
// Shared definitions for serial_reg_file: frame FSM encoding and sizing helpers.
// The optional frame parity is enabled by defining SERIAL_REG_FILE_PARITY_EN.
package serial_reg_file_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_ADDR = 3'd1;
  localparam state_t ST_TURN = 3'd2;
  localparam state_t ST_DATA = 3'd3;
  localparam state_t ST_PAR  = 3'd4;

  // Bit counter must hold max(ADDR_WIDTH, DATA_WIDTH) - 1.
  function automatic int cnt_width(input int aw, input int dw);
    return $clog2((aw > dw) ? aw : dw) + 1;
  endfunction

  // Frame length in clock cycles, strobe edge inclusive.
  function automatic int frame_len(input int aw, input int dw, input bit par);
    return 2 + aw + dw + (par ? 1 : 0);
  endfunction

endpackage

// File: rtl/serial_reg_file_ctrl.sv
// Frame controller for serial_reg_file: FSM, bit counter, mode latch, BUSY and ERR.
// Defining SERIAL_REG_FILE_PARITY_EN adds the PAR state after DATA.
module serial_reg_file_ctrl
  import serial_reg_file_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic   CLK,
  input  logic   RSTN,
  input  logic   RD_EN,
  input  logic   WR_EN,
  input  logic   hit,
  input  logic   ro,
`ifdef SERIAL_REG_FILE_PARITY_EN
  input  logic   par_ok,
`endif
  output state_t state,
  output logic   last,
  output logic   mode_wr,
  output logic   BUSY,
  output logic   ERR
);

  localparam int CW = cnt_width(ADDR_WIDTH, DATA_WIDTH);
  localparam logic [CW-1:0] ADDR_LOAD = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LOAD = CW'(DATA_WIDTH - 1);

  state_t        state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_d;
  logic          frame_end;
  logic          err_d;

  assign last = (cnt_q == '0);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state;
    cnt_d     = cnt_q;
    mode_d    = mode_wr;
    frame_end = 1'b0;
    case (state)
      ST_IDLE: if (WR_EN || RD_EN) begin
        state_d = ST_ADDR;
        cnt_d   = ADDR_LOAD;
        mode_d  = WR_EN;
      end
      ST_ADDR: if (last) state_d = ST_TURN;
               else      cnt_d   = cnt_q - CW'(1);
      ST_TURN: begin
        state_d = ST_DATA;
        cnt_d   = DATA_LOAD;
      end
      ST_DATA: if (last) begin
`ifdef SERIAL_REG_FILE_PARITY_EN
        state_d   = ST_PAR;
`else
        state_d   = ST_IDLE;
        frame_end = 1'b1;
`endif
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
`ifdef SERIAL_REG_FILE_PARITY_EN
      ST_PAR: begin
        state_d   = ST_IDLE;
        frame_end = 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Address miss, read-only write target or bad parity all abort the frame.
`ifdef SERIAL_REG_FILE_PARITY_EN
  assign err_d = frame_end & (~hit | (mode_wr & (ro | ~par_ok)));
`else
  assign err_d = frame_end & (~hit | (mode_wr & ro));
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state   <= ST_IDLE;
      cnt_q   <= '0;
      mode_wr <= 1'b0;
      BUSY    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      state   <= state_d;
      cnt_q   <= cnt_d;
      mode_wr <= mode_d;
      BUSY    <= (state_d != ST_IDLE);
      ERR     <= err_d;
    end
  end

endmodule

// File: rtl/serial_reg_file.sv
// Serial-access register file: address/shadow shift registers, decode, register array, DOUT.
// Optional frame parity is enabled by defining SERIAL_REG_FILE_PARITY_EN.
module serial_reg_file
  import serial_reg_file_pkg::*;
#(
  parameter int                              N_REG      = 5,
  parameter int                              ADDR_WIDTH = 8,
  parameter int                              DATA_WIDTH = 8,
  parameter logic [N_REG*ADDR_WIDTH-1:0]     ADDR_MAP   = 40'h5506A17834,
  parameter logic [N_REG*DATA_WIDTH-1:0]     RST_VAL    = 40'h3300000000,
  parameter logic [N_REG-1:0]                RO_MASK    = 5'b10000
) (
  input  logic                        CLK,
  input  logic                        RSTN,
  input  logic                        RD_EN,
  input  logic                        WR_EN,
  input  logic                        DIN,
  output logic                        DOUT,
  output logic                        BUSY,
  output logic                        ERR,
  output logic [N_REG*DATA_WIDTH-1:0] REG_Q
);

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;

  state_t          state;
  logic            last;
  logic            mode_wr;
  logic [AW-1:0]   addr_sr;
  logic [DW-1:0]   shadow;
  logic [N_REG-1:0] sel_d, sel_q;
  logic [DW-1:0]   lookup_d, lookup_q;
  logic [DW-1:0]   regs [N_REG];
  logic [DW-1:0]   commit_val;
  logic            commit;
  logic            hit, ro;

  assign hit = |sel_q;
  assign ro  = |(sel_q & RO_MASK);

  // Descending scan so the lowest matching index overrides higher ones.
  always_comb begin
    sel_d = '0;
    for (int i = N_REG - 1; i >= 0; i--) begin
      if (addr_sr == ADDR_MAP[i*AW +: AW]) begin
        sel_d    = '0;
        sel_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    lookup_d = '0;
    lookup_q = '0;
    for (int i = 0; i < N_REG; i++) begin
      if (sel_d[i]) lookup_d |= regs[i];
      if (sel_q[i]) lookup_q |= regs[i];
    end
  end

`ifdef SERIAL_REG_FILE_PARITY_EN
  logic par_ok;
  assign par_ok     = (DIN == ^shadow);
  assign commit_val = shadow;
  assign commit     = (state == ST_PAR) && mode_wr && hit && !ro && par_ok;
`else
  assign commit_val = {shadow[DW-2:0], DIN};
  assign commit     = (state == ST_DATA) && last && mode_wr && hit && !ro;
`endif

  serial_reg_file_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) u_ctrl (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .RD_EN   (RD_EN),
    .WR_EN   (WR_EN),
    .hit     (hit),
    .ro      (ro),
`ifdef SERIAL_REG_FILE_PARITY_EN
    .par_ok  (par_ok),
`endif
    .state   (state),
    .last    (last),
    .mode_wr (mode_wr),
    .BUSY    (BUSY),
    .ERR     (ERR)
  );

  // NOTE: the register array is a handful of flops with individual reset values, so it is reset like any other state.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < N_REG; i++) regs[i] <= RST_VAL[i*DW +: DW];
    end else if (commit) begin
      for (int i = 0; i < N_REG; i++) if (sel_q[i]) regs[i] <= commit_val;
    end
  end

  // Shadow shifts on every DATA edge; for reads its next-to-MSB feeds DOUT.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      addr_sr <= '0;
      shadow  <= '0;
      sel_q   <= '0;
      DOUT    <= 1'b0;
    end else begin
      DOUT <= 1'b0;
      case (state)
        ST_ADDR: addr_sr <= {addr_sr[AW-2:0], DIN};
        ST_TURN: begin
          sel_q  <= sel_d;
          shadow <= lookup_d;
          DOUT   <= ~mode_wr & lookup_d[DW-1];
        end
        ST_DATA: begin
          shadow <= {shadow[DW-2:0], DIN};
          if (!mode_wr && !last) DOUT <= shadow[DW-2];
`ifdef SERIAL_REG_FILE_PARITY_EN
          if (!mode_wr && last)  DOUT <= ^lookup_q;
`endif
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N_REG; g++) begin : g_regq
    assign REG_Q[g*DW +: DW] = regs[g];
  end

endmodule

// File: tb/tb_serial_reg_file.sv
// Self-checking bench for serial_reg_file: frame-level reference model plus per-cycle compare.
// Also builds with SERIAL_REG_FILE_PARITY_EN defined, which enables the parity scenarios.
module tb_serial_reg_file;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int N  = 5;
`ifdef SERIAL_REG_FILE_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int L = 2 + AW + DW + PAR;
  localparam logic [7:0] MAP [N] = '{8'h34, 8'h78, 8'hA1, 8'h06, 8'h55};

  logic        CLK, RSTN, RD_EN, WR_EN, DIN;
  logic        DOUT, BUSY, ERR;
  logic [39:0] REG_Q;

  serial_reg_file dut (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .RD_EN (RD_EN),
    .WR_EN (WR_EN),
    .DIN   (DIN),
    .DOUT  (DOUT),
    .BUSY  (BUSY),
    .ERR   (ERR),
    .REG_Q (REG_Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] m_reg [N];
  logic exp_busy, exp_dout, exp_err;
  bit   chk_en = 0;

  logic [7:0] cap;
  logic       cap_par;
  int         busy_cnt, err_cnt;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [39:0] model_q();
    logic [39:0] q;
    for (int i = 0; i < N; i++) q[i*8 +: 8] = m_reg[i];
    return q;
  endfunction

  function automatic int lookup(input logic [7:0] a);
    for (int i = 0; i < N; i++) if (MAP[i] == a) return i;
    return -1;
  endfunction

  function automatic logic din_for(input int j, input logic [7:0] a, input logic [7:0] d, input bit p);
    if (j >= 1 && j <= AW) return a[AW-j];
    if (j >= AW + 2 && j <= AW + DW + 1) return d[DW-1-(j-AW-2)];
    if (PAR == 1 && j == AW + DW + 2) return p;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic model_reset();
    m_reg    = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h33};
    exp_busy = 1'b0;
    exp_dout = 1'b0;
    exp_err  = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("busy",  {63'd0, BUSY}, {63'd0, exp_busy});
      check("dout",  {63'd0, DOUT}, {63'd0, exp_dout});
      check("err",   {63'd0, ERR},  {63'd0, exp_err});
      check("reg_q", {24'd0, REG_Q}, {24'd0, model_q()});
    end
  end

  task automatic idle(input int n);
    WR_EN = 1'b0;
    RD_EN = 1'b0;
    repeat (n) begin
      @(posedge CLK); #1;
      exp_busy = 1'b0;
      exp_dout = 1'b0;
      exp_err  = 1'b0;
      DIN      = 1'($urandom_range(0, 1));
    end
  endtask

  // One complete frame; abort_at >= 0 pulls RSTN low right after that edge.
  task automatic frame(input bit wr, input bit rd, input logic [7:0] addr, input logic [7:0] data,
                       input bit par_bit, input int abort_at, input bit noise);
    int         hit_i;
    bit         is_wr, e;
    logic [7:0] rv;
    hit_i = lookup(addr);
    is_wr = wr;
    e     = (hit_i < 0) || (is_wr && hit_i == 4) || (PAR == 1 && is_wr && (par_bit != ^data));
    rv    = (hit_i >= 0) ? m_reg[hit_i] : 8'h00;
    cap = '0; cap_par = 1'b0; busy_cnt = 0; err_cnt = 0;
    WR_EN = wr;
    RD_EN = rd;
    DIN   = 1'($urandom_range(0, 1));
    for (int k = 0; k < L; k++) begin
      @(posedge CLK); #1;
      if (k == abort_at) begin
        RSTN  = 1'b0;
        WR_EN = 1'b0;
        RD_EN = 1'b0;
        model_reset();
        @(posedge CLK); #1;
        RSTN = 1'b1;
        return;
      end
      exp_busy = (k < L - 1);
      if (!is_wr && k >= AW + 1 && k <= AW + DW) exp_dout = rv[DW-1-(k-AW-1)];
      else if (PAR == 1 && !is_wr && k == AW + DW + 1) exp_dout = ^rv;
      else exp_dout = 1'b0;
      exp_err = (k == L - 1) && e;
      if (k == L - 1 && is_wr && !e) m_reg[hit_i] = data;
      if (k >= AW + 1 && k <= AW + DW) cap = {cap[6:0], DOUT};
      if (PAR == 1 && k == AW + DW + 1) cap_par = DOUT;
      busy_cnt += int'(BUSY);
      err_cnt  += int'(ERR);
      if (noise && k < L - 1) begin
        WR_EN = 1'($urandom_range(0, 1));
        RD_EN = 1'($urandom_range(0, 1));
      end else begin
        WR_EN = 1'b0;
        RD_EN = 1'b0;
      end
      DIN = din_for(k + 1, addr, data, par_bit);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    RSTN = 1'b0; WR_EN = 1'b0; RD_EN = 1'b0; DIN = 1'b0;
    model_reset();
    #1 chk_en = 1;
    repeat (2) @(posedge CLK);
    #1 RSTN = 1'b1;
    check("rst_regq", {24'd0, REG_Q}, 64'h33_0000_0000);
    idle(2);

    // Read of the read-only register after reset returns its reset value.
    frame(0, 1, 8'h55, 8'h00, 1'b0, -1, 0);
    check("rd55_data", {56'd0, cap}, 64'h33);
    check("rd55_err", err_cnt, 0);
    idle(1);
    frame(1, 0, 8'h55, 8'hFF, 1'b0, -1, 0);
    check("wr55_err", err_cnt, 1);
    check("wr55_keep", {56'd0, REG_Q[39:32]}, 64'h33);
    idle(1);

    frame(1, 0, 8'h78, 8'hC3, 1'b0, -1, 0);
    check("wr78_regq", {56'd0, REG_Q[15:8]}, 64'hC3);
    check("wr78_err", err_cnt, 0);
    frame(0, 1, 8'h78, 8'h00, 1'b0, -1, 0);
    check("rd78_data", {56'd0, cap}, 64'hC3);
    check("rd78_err", err_cnt, 0);
    idle(2);

    // Unmapped read: silent DOUT, one ERR, BUSY high from E0 up to the final edge.
    frame(0, 1, 8'hFF, 8'h00, 1'b0, -1, 0);
    check("rdFF_data", {56'd0, cap}, 64'h00);
    check("rdFF_err", err_cnt, 1);
    check("rdFF_busy", busy_cnt, AW + DW + 1 + PAR);
    idle(1);

    // Both strobes: write wins; mid-frame strobe noise is ignored.
    frame(1, 1, 8'hA1, 8'h5C, ^8'h5C, -1, 1);
    check("both_regq", {56'd0, REG_Q[23:16]}, 64'h5C);
    idle(1);

    frame(1, 0, 8'h34, 8'hAA, ^8'hAA, 10, 0);
    check("abort_reg0", {56'd0, REG_Q[7:0]}, 64'h00);
    check("abort_reg2", {56'd0, REG_Q[23:16]}, 64'h00);
    idle(1);
    frame(1, 0, 8'h34, 8'h5A, ^8'h5A, -1, 0);
    frame(0, 1, 8'h34, 8'h00, 1'b0, -1, 0);
    check("after_abort_rd", {56'd0, cap}, 64'h5A);
    idle(1);

`ifdef SERIAL_REG_FILE_PARITY_EN
    frame(1, 0, 8'h06, 8'h81, 1'b0, -1, 0);
    check("par_ok_commit", {56'd0, REG_Q[31:24]}, 64'h81);
    check("par_ok_err", err_cnt, 0);
    frame(1, 0, 8'hA1, 8'h81, 1'b1, -1, 0);
    check("par_bad_err", err_cnt, 1);
    check("par_bad_keep", {56'd0, REG_Q[23:16]}, 64'h00);
    frame(0, 1, 8'h06, 8'h00, 1'b0, -1, 0);
    check("par_rd_data", {56'd0, cap}, 64'h81);
    check("par_rd_bit", {63'd0, cap_par}, 64'h0);
    idle(1);
`endif

    for (int t = 0; t < 250; t++) begin
      logic [7:0] a, d;
      bit         w, r, p;
      int         ab, kind;
      kind = int'($urandom_range(0, 2));
      w = (kind != 1);
      r = (kind != 0);
      a = ($urandom_range(0, 3) != 0) ? MAP[$urandom_range(0, N - 1)] : 8'($urandom);
      d = 8'($urandom);
      p = (^d) ^ ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, L - 1)) : -1;
      frame(w, r, a, d, p, ab, 1'($urandom_range(0, 1)));
      idle(int'($urandom_range(0, 2)));
    end

    idle(2);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
